// File: rtl/z80_djnz_sequencer.sv
// DJNZ e post-M1 sequencer: extended M1, displacement read, and the optional
// branch-taken internal cycle, then the B and PC write-back to the register file.
module z80_djnz_sequencer #(
  parameter int unsigned EXT_T = 1,
  parameter int unsigned RD_T  = 3,
  parameter int unsigned INT_T = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  b_in,
  input  logic [15:0] pc_in,
  input  logic        wait_n,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic [2:0]  mcycle,
  output logic [2:0]  tstate,
  output logic [15:0] mem_addr,
  output logic        mreq_n,
  output logic        rd_n,
  output logic [7:0]  b_out,
  output logic        b_we,
  output logic [15:0] pc_out,
  output logic        pc_we,
  output logic        done
);

  localparam int unsigned WCNT_W = 8;
  localparam logic [WCNT_W-1:0] FIX_WAITS = WCNT_W'(RD_T - 3);
  localparam logic [2:0] EXT_LAST = 3'(EXT_T);
  localparam logic [2:0] INT_LAST = 3'(INT_T);

  localparam logic [2:0] MC_NONE = 3'd0;
  localparam logic [2:0] MC_EXT  = 3'd1;
  localparam logic [2:0] MC_RD   = 3'd2;
  localparam logic [2:0] MC_INT  = 3'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_EXT, S_RD_T1, S_RD_T2, S_RD_TW, S_RD_T3, S_INT, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        tcnt_q, tcnt_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [7:0]        b_q, b_d;
  logic [15:0]       pc_q, pc_d;
  logic [7:0]        e_q, e_d;
  logic              taken_q, taken_d;

  logic              busy_d, mreq_n_d, rd_n_d, b_we_d, pc_we_d, done_d;
  logic [2:0]        mcycle_d, tstate_d;
  logic [15:0]       mem_addr_d, pc_out_d;
  logic [7:0]        b_out_d;
  logic              rd_c;
  logic [15:0]       disp_c;

  // State register plus registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      tcnt_q   <= 3'd0;
      wcnt_q   <= '0;
      b_q      <= 8'd0;
      pc_q     <= 16'd0;
      e_q      <= 8'd0;
      taken_q  <= 1'b0;
      busy     <= 1'b0;
      mcycle   <= MC_NONE;
      tstate   <= 3'd0;
      mem_addr <= 16'd0;
      mreq_n   <= 1'b1;
      rd_n     <= 1'b1;
      b_out    <= 8'd0;
      b_we     <= 1'b0;
      pc_out   <= 16'd0;
      pc_we    <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      tcnt_q   <= tcnt_d;
      wcnt_q   <= wcnt_d;
      b_q      <= b_d;
      pc_q     <= pc_d;
      e_q      <= e_d;
      taken_q  <= taken_d;
      busy     <= busy_d;
      mcycle   <= mcycle_d;
      tstate   <= tstate_d;
      mem_addr <= mem_addr_d;
      mreq_n   <= mreq_n_d;
      rd_n     <= rd_n_d;
      b_out    <= b_out_d;
      b_we     <= b_we_d;
      pc_out   <= pc_out_d;
      pc_we    <= pc_we_d;
      done     <= done_d;
    end
  end

  // Next state; outputs are decoded from the next state so they register in step
  always_comb begin
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    wcnt_d     = wcnt_q;
    b_d        = b_q;
    pc_d       = pc_q;
    e_d        = e_q;
    taken_d    = taken_q;
    b_out_d    = b_out;
    pc_out_d   = pc_out;
    busy_d     = 1'b0;
    mcycle_d   = MC_NONE;
    tstate_d   = 3'd0;
    mem_addr_d = 16'd0;
    mreq_n_d   = 1'b1;
    rd_n_d     = 1'b1;
    b_we_d     = 1'b0;
    pc_we_d    = 1'b0;
    done_d     = 1'b0;
    rd_c       = 1'b0;
    disp_c     = 16'd0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          b_d     = b_in;
          pc_d    = pc_in;
          b_out_d = b_in - 8'd1;
          tcnt_d  = 3'd1;
          state_d = S_EXT;
        end
      end
      S_EXT: begin
        if (tcnt_q >= EXT_LAST) begin
          taken_d = (b_q != 8'h01);
          state_d = S_RD_T1;
        end else begin
          tcnt_d = tcnt_q + 3'd1;
        end
      end
      S_RD_T1: begin
        wcnt_d  = '0;
        state_d = S_RD_T2;
      end
      S_RD_T2, S_RD_TW: begin
        // Leave for T3 only once the bus is ready and the fixed waits are spent
        if (wait_n && (wcnt_q >= FIX_WAITS)) begin
          state_d = S_RD_T3;
        end else begin
          wcnt_d  = (wcnt_q == '1) ? wcnt_q : wcnt_q + WCNT_W'(1);
          state_d = S_RD_TW;
        end
      end
      S_RD_T3: begin
        e_d = mem_rdata;
        if (taken_q) begin
          tcnt_d  = 3'd1;
          state_d = S_INT;
        end else begin
          state_d = S_DONE;
        end
      end
      S_INT: begin
        if (tcnt_q >= INT_LAST) begin
          state_d = S_DONE;
        end else begin
          tcnt_d = tcnt_q + 3'd1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    rd_c   = (state_d == S_RD_T1) || (state_d == S_RD_T2) ||
             (state_d == S_RD_TW) || (state_d == S_RD_T3);

    case (state_d)
      S_EXT: begin
        mcycle_d = MC_EXT;
        tstate_d = tcnt_d;
      end
      S_RD_T1: begin
        mcycle_d = MC_RD;
        tstate_d = 3'd1;
      end
      S_RD_T2, S_RD_TW: begin
        mcycle_d = MC_RD;
        tstate_d = 3'd2;
      end
      S_RD_T3: begin
        mcycle_d = MC_RD;
        tstate_d = 3'd3;
      end
      S_INT: begin
        mcycle_d = MC_INT;
        tstate_d = tcnt_d;
      end
      default: begin
        mcycle_d = MC_NONE;
        tstate_d = 3'd0;
      end
    endcase

    if (rd_c) begin
      mem_addr_d = pc_q + 16'd1;
      mreq_n_d   = 1'b0;
      rd_n_d     = 1'b0;
    end

    b_we_d = (state_d == S_EXT) && (tcnt_d >= EXT_LAST) && (state_q == S_EXT || state_q == S_IDLE);

    if (state_d == S_DONE) begin
      disp_c   = taken_q ? {{8{e_d[7]}}, e_d} : 16'd0;
      pc_out_d = pc_q + 16'd2 + disp_c;
      pc_we_d  = 1'b1;
      done_d   = 1'b1;
    end
  end

endmodule
